pe_traffic_gen: RTL and testbench
=================================

Name: pe_traffic_gen

Overview:
Per-node synthetic traffic source that sits directly upstream of the network's local injection port. It drives i_data/i_data_val for one node, one instance per PE. It generates packets under a programmable Bernoulli injection rate, with LFSR-random destinations. Packets queue in a small source FIFO and inject under the network's local-port enable. Cycle timestamps and counters support latency and throughput measurement.

Parameters:
NODE_ID, 0, index of this node; used as packet source field.
NODES, 16, node count; destinations lie in 0..NODES-1.
FIFO_DEPTH, 4, source-queue entries; power of two, at least 2.
SEQ_W, 8, sequence-number width; wraps modulo 2^SEQ_W.
TS_W, 16, timestamp and cycle-counter width; wraps.
LFSR_SEED, 16'hACE1, reset value of the LFSR; must be non-zero. Give each node a distinct seed.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_enable  in  1  start/continue generation
i_rate  in  8  injection threshold; per-cycle probability = i_rate/256
i_pkt_limit  in  16  packets to generate; 0 = unlimited
i_en  in  1  network local-port enable (ready)
o_data_val  out  1  packet valid toward network
o_source  out  $clog2(NODES)  packet source (= NODE_ID)
o_dest  out  $clog2(NODES)  packet destination
o_seq  out  SEQ_W  packet sequence number
o_timestamp  out  TS_W  generation cycle
o_gen_count  out  16  packets generated
o_sent_count  out  16  packets accepted by network
o_drop_count  out  16  packets dropped on full FIFO
o_done  out  1  run complete

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; FIFO empty; LFSR=LFSR_SEED; cycle counter 0.
- Cycle counter: free-running +1 every cycle after reset; wraps at 2^TS_W.
- LFSR: 16-bit Galois, taps 16'hB400.
  - Shift: lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 0).
  - Advances every cycle in RUN only.
- FSM IDLE -> RUN: when i_enable=1.
  - On this transition, clear o_gen_count, o_sent_count, o_drop_count, o_seq and o_done.
- FSM RUN, generation:
  - A packet is generated in a cycle when lfsr[7:0] < i_rate. i_rate=0 never generates; i_rate=255 generates 255 cycles in 256.
  - Destination d = lfsr[15:8] mod NODES. If d == NODE_ID, use (NODE_ID+1) mod NODES.
  - Packet fields: source = NODE_ID; seq = current sequence number; timestamp = current cycle count.
  - A generated packet always increments o_gen_count and the sequence number.
  - If the FIFO is not full, the packet is written. If full (and no pop this cycle), it is discarded and o_drop_count increments.
  - A simultaneous push and pop on a full FIFO is legal and counts as no drop.
- FSM RUN -> DRAIN:
  - when i_pkt_limit != 0 and o_gen_count reaches i_pkt_limit (evaluated with the post-increment value, so no further generation), or
  - when i_enable=0.
- FSM DRAIN: no generation; the LFSR holds. DRAIN -> DONE when the FIFO is empty.
- FSM DONE: o_done=1. DONE -> IDLE when i_enable=0; o_done stays 1 until the next IDLE -> RUN.
- Injection handshake:
  - o_data_val = FIFO not empty; registered, with no combinational path from i_en.
  - The head packet is presented on o_source/o_dest/o_seq/o_timestamp.
  - It is popped when o_data_val && i_en; o_sent_count increments in that cycle.
  - Head fields stay stable while o_data_val=1 and i_en=0.
- Latency: a packet written into an empty FIFO is visible on the outputs in the next cycle.
- Wrap: counters wrap silently at their widths; o_seq wraps at 2^SEQ_W.
- Reset mid-operation: all state returns to reset values in the next cycle. Queued packets are discarded and not counted.
- Invariant: o_gen_count = o_sent_count + o_drop_count + FIFO occupancy (mod 2^16).

Test Plan:
- Reset: assert reset 2 cycles with i_enable=1 -> all outputs 0; LFSR=16'hACE1 internally.
- Full rate, free network: i_rate=255, i_en=1, i_pkt_limit=20 -> o_gen_count=20 and o_sent_count=20 at o_done; o_drop_count=0; o_seq values 0..19 in order; no o_dest equals NODE_ID.
- Backpressure: i_rate=255, i_en=0 for 30 cycles, FIFO_DEPTH=4 -> exactly 4 packets held; head fields stable; drops = generated - 4. Releasing i_en -> 4 packets injected on consecutive cycles.
- Zero rate: i_rate=0, i_enable=1 for 1000 cycles -> o_gen_count=0 and o_data_val never 1. Dropping i_enable -> o_done=1 within 2 cycles.
- Self-destination remap: with NODE_ID=3 and NODES=16, force a seed where lfsr[15:8] mod 16 = 3 -> the emitted packet has o_dest=4.
- Mid-run reset: reset with 3 packets queued -> o_data_val=0 the next cycle; counters 0; the following run restarts seq at 0.

Source files
------------

// File: rtl/pe_traffic_gen.sv
// pe_traffic_gen: per-node synthetic traffic source feeding one local
// injection port. Bernoulli injection under i_rate, LFSR-random
// destinations, a small source FIFO drained under the network enable, and
// counters for throughput/latency measurement.
//
// Ports
//   clk, reset     clock, synchronous active-high reset
//   i_enable       start/continue generation
//   i_rate         per-cycle injection probability = i_rate/256
//   i_pkt_limit    packets to generate per run (0 = unlimited)
//   i_en           network local-port ready
//   o_data_val     head packet valid (registered, independent of i_en)
//   o_source       head packet source (= NODE_ID)
//   o_dest         head packet destination (never NODE_ID)
//   o_seq          head packet sequence number
//   o_timestamp    head packet generation cycle
//   o_gen_count    packets generated this run
//   o_sent_count   packets accepted by the network this run
//   o_drop_count   packets discarded on a full FIFO this run
//   o_done         run complete; held until the next run starts
module pe_traffic_gen #(
  parameter int unsigned NODE_ID    = 0,
  parameter int unsigned NODES      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SEQ_W      = 8,
  parameter int unsigned TS_W       = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_enable,
  input  logic [7:0]               i_rate,
  input  logic [15:0]              i_pkt_limit,
  input  logic                     i_en,
  output logic                     o_data_val,
  output logic [$clog2(NODES)-1:0] o_source,
  output logic [$clog2(NODES)-1:0] o_dest,
  output logic [SEQ_W-1:0]         o_seq,
  output logic [TS_W-1:0]          o_timestamp,
  output logic [15:0]              o_gen_count,
  output logic [15:0]              o_sent_count,
  output logic [15:0]              o_drop_count,
  output logic                     o_done
);

  localparam int unsigned NODE_W    = $clog2(NODES);
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [15:0]       lfsr_q;
  logic [15:0]       lfsr_next;
  logic [TS_W-1:0]   cycle_q;
  logic [SEQ_W-1:0]  seq_q;

  // FIFO storage; the source field is constant so it is not stored
  logic [NODE_W-1:0] mem_dest [FIFO_DEPTH];
  logic [SEQ_W-1:0]  mem_seq  [FIFO_DEPTH];
  logic [TS_W-1:0]   mem_ts   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_d;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [CNT_W-1:0]  remain_cnt;

  // Control decoded by the FSM
  logic              start;
  logic              lfsr_adv;
  logic              gen;
  logic              limit_hit;
  logic [15:0]       gen_count_inc;

  // FIFO handshake
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;

  // Generated packet and next head
  logic [NODE_W-1:0] dest_raw;
  logic [NODE_W-1:0] pkt_dest;
  logic [NODE_W-1:0] head_dest_d;
  logic [SEQ_W-1:0]  head_seq_d;
  logic [TS_W-1:0]   head_ts_d;

  // Galois LFSR step and destination derivation with self-remap
  always_comb begin
    lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    dest_raw  = NODE_W'(32'(lfsr_q[15:8]) % NODES);
    pkt_dest  = dest_raw;
    if (dest_raw == NODE_W'(NODE_ID)) begin
      pkt_dest = NODE_W'((NODE_ID + 1) % NODES);
    end
  end

  // FIFO status; a pop frees the slot a same-cycle push needs
  always_comb begin
    full = (count_q == CNT_W'(FIFO_DEPTH));
    pop  = o_data_val & i_en;
    push = gen & (~full | pop);
    drop = gen & full & ~pop;
  end

  // Next-state and run control
  always_comb begin
    state_d       = state_q;
    start         = 1'b0;
    lfsr_adv      = 1'b0;
    gen           = 1'b0;
    limit_hit     = 1'b0;
    gen_count_inc = o_gen_count + 16'd1;
    case (state_q)
      ST_IDLE: begin
        if (i_enable) begin
          state_d = ST_RUN;
          start   = 1'b1;
        end
      end
      ST_RUN: begin
        lfsr_adv  = 1'b1;
        gen       = (lfsr_q[7:0] < i_rate);
        limit_hit = gen && (i_pkt_limit != 16'd0) && (gen_count_inc == i_pkt_limit);
        if (!i_enable || limit_hit) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (count_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO pointer/occupancy update and next head selection
  always_comb begin
    rd_ptr_d   = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    remain_cnt = count_q - CNT_W'(pop);
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // With nothing left after the pop, the head is the packet being pushed
    if (remain_cnt == '0) begin
      head_dest_d = pkt_dest;
      head_seq_d  = seq_q;
      head_ts_d   = cycle_q;
    end else begin
      head_dest_d = mem_dest[rd_ptr_d];
      head_seq_d  = mem_seq[rd_ptr_d];
      head_ts_d   = mem_ts[rd_ptr_d];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // LFSR, cycle counter and sequence number
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q  <= LFSR_SEED;
      cycle_q <= '0;
      seq_q   <= '0;
    end else begin
      cycle_q <= cycle_q + TS_W'(1);
      if (lfsr_adv) begin
        lfsr_q <= lfsr_next;
      end
      if (start) begin
        seq_q <= '0;
      end else if (gen) begin
        seq_q <= seq_q + SEQ_W'(1);
      end
    end
  end

  // FIFO storage writes (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_dest[wr_ptr_q] <= pkt_dest;
      mem_seq[wr_ptr_q]  <= seq_q;
      mem_ts[wr_ptr_q]   <= cycle_q;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Registered head presentation; fields hold while the FIFO is empty
  always_ff @(posedge clk) begin
    if (reset) begin
      o_data_val  <= 1'b0;
      o_source    <= '0;
      o_dest      <= '0;
      o_seq       <= '0;
      o_timestamp <= '0;
    end else begin
      o_data_val <= (count_d != '0);
      if (count_d != '0) begin
        o_source    <= NODE_W'(NODE_ID);
        o_dest      <= head_dest_d;
        o_seq       <= head_seq_d;
        o_timestamp <= head_ts_d;
      end
    end
  end

  // Run statistics and completion flag
  always_ff @(posedge clk) begin
    if (reset) begin
      o_gen_count  <= '0;
      o_sent_count <= '0;
      o_drop_count <= '0;
      o_done       <= 1'b0;
    end else if (start) begin
      o_gen_count  <= '0;
      o_sent_count <= '0;
      o_drop_count <= '0;
      o_done       <= 1'b0;
    end else begin
      if (gen) begin
        o_gen_count <= gen_count_inc;
      end
      if (pop) begin
        o_sent_count <= o_sent_count + 16'd1;
      end
      if (drop) begin
        o_drop_count <= o_drop_count + 16'd1;
      end
      if (state_d == ST_DONE) begin
        o_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pe_traffic_gen.sv
// Directed testbench for pe_traffic_gen. Main instance: NODE_ID=0, seed
// 16'hACE1. Second instance: NODE_ID=3 with a seed whose first state maps
// to destination 3, exercising the self-destination remap.
module tb_pe_traffic_gen;

  localparam int unsigned NODES = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_enable;
  logic [7:0]  i_rate;
  logic [15:0] i_pkt_limit;
  logic        i_en;
  logic        o_data_val;
  logic [3:0]  o_source;
  logic [3:0]  o_dest;
  logic [7:0]  o_seq;
  logic [15:0] o_timestamp;
  logic [15:0] o_gen_count;
  logic [15:0] o_sent_count;
  logic [15:0] o_drop_count;
  logic        o_done;

  logic        r_enable;
  logic [7:0]  r_rate;
  logic [15:0] r_limit;
  logic        r_en;
  logic        r_data_val;
  logic [3:0]  r_source;
  logic [3:0]  r_dest;
  logic [7:0]  r_seq;
  logic [15:0] r_timestamp;
  logic [15:0] r_gen_count;
  logic [15:0] r_sent_count;
  logic [15:0] r_drop_count;
  logic        r_done;

  int checks = 0;
  int errors = 0;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  pe_traffic_gen #(
    .NODE_ID(0), .NODES(16), .FIFO_DEPTH(4), .SEQ_W(8), .TS_W(16), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_rate(i_rate),
    .i_pkt_limit(i_pkt_limit), .i_en(i_en), .o_data_val(o_data_val),
    .o_source(o_source), .o_dest(o_dest), .o_seq(o_seq), .o_timestamp(o_timestamp),
    .o_gen_count(o_gen_count), .o_sent_count(o_sent_count),
    .o_drop_count(o_drop_count), .o_done(o_done)
  );

  pe_traffic_gen #(
    .NODE_ID(3), .NODES(16), .FIFO_DEPTH(4), .SEQ_W(8), .TS_W(16), .LFSR_SEED(16'h0300)
  ) dut_remap (
    .clk(clk), .reset(reset), .i_enable(r_enable), .i_rate(r_rate),
    .i_pkt_limit(r_limit), .i_en(r_en), .o_data_val(r_data_val),
    .o_source(r_source), .o_dest(r_dest), .o_seq(r_seq), .o_timestamp(r_timestamp),
    .o_gen_count(r_gen_count), .o_sent_count(r_sent_count),
    .o_drop_count(r_drop_count), .o_done(r_done)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [3:0] model_dest(input logic [15:0] s, input int unsigned node_id);
    int unsigned d;
    d = 32'(s[15:8]) % NODES;
    if (d == node_id) d = (node_id + 1) % NODES;
    return 4'(d);
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; i_enable = 1'b1; i_rate = 8'd255; i_pkt_limit = 16'd20; i_en = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (o_data_val !== 1'b0) begin errors++; $display("FAIL reset_data_val: got %0b expected 0", o_data_val); end
    checks++; if (o_source !== 4'd0) begin errors++; $display("FAIL reset_source: got %0d expected 0", o_source); end
    checks++; if (o_dest !== 4'd0) begin errors++; $display("FAIL reset_dest: got %0d expected 0", o_dest); end
    checks++; if (o_seq !== 8'd0) begin errors++; $display("FAIL reset_seq: got %0d expected 0", o_seq); end
    checks++; if (o_timestamp !== 16'd0) begin errors++; $display("FAIL reset_timestamp: got %0d expected 0", o_timestamp); end
    checks++; if (o_gen_count !== 16'd0) begin errors++; $display("FAIL reset_gen_count: got %0d expected 0", o_gen_count); end
    checks++; if (o_sent_count !== 16'd0) begin errors++; $display("FAIL reset_sent_count: got %0d expected 0", o_sent_count); end
    checks++; if (o_drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count: got %0d expected 0", o_drop_count); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", o_done); end
    checks++; if (dut.lfsr_q !== 16'hACE1) begin errors++; $display("FAIL reset_lfsr: got %h expected ace1", dut.lfsr_q); end
    checks++; if (r_data_val !== 1'b0) begin errors++; $display("FAIL reset_remap_val: got %0b expected 0", r_data_val); end
    i_enable = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (o_data_val !== 1'b0) begin errors++; $display("FAIL idle_data_val: got %0b expected 0", o_data_val); end
    m_lfsr = 16'hACE1;
  endtask

  task automatic test_full_rate();
    logic [3:0]  exp_dest [20];
    int          exp_idx  [20];
    logic [3:0]  got_dest [$];
    logic [3:0]  got_src  [$];
    logic [7:0]  got_seq  [$];
    logic [15:0] got_ts   [$];
    logic [15:0] m;
    int n, k;
    bit done_seen;
    m = m_lfsr; n = 0; k = 0;
    while (n < 20) begin
      if (m[7:0] != 8'hFF) begin
        exp_dest[n] = model_dest(m, 0);
        exp_idx[n]  = k;
        n++;
      end
      m = lfsr_step(m);
      k++;
    end
    m_lfsr = m;
    i_rate = 8'd255; i_pkt_limit = 16'd20; i_en = 1'b1; i_enable = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 200 && !done_seen; c++) begin
      @(negedge clk);
      if (o_data_val && i_en) begin
        got_dest.push_back(o_dest); got_src.push_back(o_source);
        got_seq.push_back(o_seq); got_ts.push_back(o_timestamp);
      end
      if (o_done) done_seen = 1'b1;
    end
    checks++; if (!done_seen) begin errors++; $display("FAIL full_done: got 0 expected 1 within 200 cycles"); end
    checks++; if (got_seq.size() != 20) begin errors++; $display("FAIL full_pkt_count: got %0d expected 20", got_seq.size()); end
    for (int i = 0; i < got_seq.size() && i < 20; i++) begin
      checks++; if (got_seq[i] !== 8'(i)) begin errors++; $display("FAIL full_seq[%0d]: got %0d expected %0d", i, got_seq[i], i); end
      checks++; if (got_dest[i] !== exp_dest[i]) begin errors++; $display("FAIL full_dest[%0d]: got %0d expected %0d", i, got_dest[i], exp_dest[i]); end
      checks++; if (got_src[i] !== 4'd0) begin errors++; $display("FAIL full_src[%0d]: got %0d expected 0", i, got_src[i]); end
      checks++; if (16'(got_ts[i] - got_ts[0]) !== 16'(exp_idx[i] - exp_idx[0])) begin
        errors++; $display("FAIL full_ts_delta[%0d]: got %0d expected %0d", i, 16'(got_ts[i] - got_ts[0]), exp_idx[i] - exp_idx[0]);
      end
    end
    checks++; if (o_gen_count !== 16'd20) begin errors++; $display("FAIL full_gen_count: got %0d expected 20", o_gen_count); end
    checks++; if (o_sent_count !== 16'd20) begin errors++; $display("FAIL full_sent_count: got %0d expected 20", o_sent_count); end
    checks++; if (o_drop_count !== 16'd0) begin errors++; $display("FAIL full_drop_count: got %0d expected 0", o_drop_count); end
    i_enable = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL done_hold_idle: got %0b expected 1", o_done); end
  endtask

  task automatic test_backpressure();
    logic [3:0]  exp_dest [$];
    logic [3:0]  got_dest [$];
    logic [7:0]  got_seq  [$];
    int          got_cyc  [$];
    logic [15:0] m;
    logic [3:0]  hd_dest;
    logic [7:0]  hd_seq;
    logic [15:0] hd_ts;
    int gen30, n_exp;
    bit g31, head_ok, first, done_seen;
    logic [3:0] dest31;
    m = m_lfsr; gen30 = 0;
    for (int i = 0; i < 30; i++) begin
      if (m[7:0] != 8'hFF) begin exp_dest.push_back(model_dest(m, 0)); gen30++; end
      m = lfsr_step(m);
    end
    g31 = (m[7:0] != 8'hFF);
    dest31 = model_dest(m, 0);
    m = lfsr_step(lfsr_step(m));
    m_lfsr = m;
    n_exp = 4 + int'(g31);

    i_en = 1'b0; i_rate = 8'd255; i_pkt_limit = 16'd0; i_enable = 1'b1;
    @(posedge clk);
    head_ok = 1'b1; first = 1'b1;
    hd_dest = '0; hd_seq = '0; hd_ts = '0;
    repeat (31) begin
      @(negedge clk);
      if (o_data_val) begin
        if (first) begin
          hd_dest = o_dest; hd_seq = o_seq; hd_ts = o_timestamp; first = 1'b0;
        end else if (o_dest !== hd_dest || o_seq !== hd_seq || o_timestamp !== hd_ts) begin
          head_ok = 1'b0;
        end
      end
    end
    checks++; if (o_data_val !== 1'b1) begin errors++; $display("FAIL bp_data_val: got %0b expected 1", o_data_val); end
    checks++; if (head_ok !== 1'b1) begin errors++; $display("FAIL bp_head_stable: got %0b expected 1", head_ok); end
    checks++; if (o_seq !== 8'd0) begin errors++; $display("FAIL bp_head_seq: got %0d expected 0", o_seq); end
    checks++; if (o_dest !== exp_dest[0]) begin errors++; $display("FAIL bp_head_dest: got %0d expected %0d", o_dest, exp_dest[0]); end
    checks++; if (o_gen_count !== 16'(gen30)) begin errors++; $display("FAIL bp_gen_count: got %0d expected %0d", o_gen_count, gen30); end
    checks++; if (o_drop_count !== 16'(gen30 - 4)) begin errors++; $display("FAIL bp_drop_count: got %0d expected %0d", o_drop_count, gen30 - 4); end
    checks++; if (o_sent_count !== 16'd0) begin errors++; $display("FAIL bp_sent_count: got %0d expected 0", o_sent_count); end

    // Release with generation still on for one cycle: push onto a full FIFO with a pop
    i_en = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      if (c == 1) begin i_enable = 1'b0; i_rate = 8'd0; end
      if (o_data_val && i_en) begin
        got_dest.push_back(o_dest); got_seq.push_back(o_seq); got_cyc.push_back(c);
      end
      if (o_done) done_seen = 1'b1;
      @(negedge clk);
    end
    if (g31) exp_dest.insert(4, dest31);
    checks++; if (!done_seen) begin errors++; $display("FAIL bp_done: got 0 expected 1 within 20 cycles"); end
    checks++; if (got_seq.size() != n_exp) begin errors++; $display("FAIL bp_pkt_count: got %0d expected %0d", got_seq.size(), n_exp); end
    for (int i = 0; i < got_seq.size() && i < n_exp; i++) begin
      checks++; if (got_seq[i] !== ((i < 4) ? 8'(i) : 8'(gen30))) begin
        errors++; $display("FAIL bp_seq[%0d]: got %0d expected %0d", i, got_seq[i], (i < 4) ? i : gen30);
      end
      checks++; if (got_dest[i] !== exp_dest[i]) begin errors++; $display("FAIL bp_dest[%0d]: got %0d expected %0d", i, got_dest[i], exp_dest[i]); end
      checks++; if (got_cyc[i] != i) begin errors++; $display("FAIL bp_consecutive[%0d]: got cycle %0d expected %0d", i, got_cyc[i], i); end
    end
    checks++; if (o_sent_count !== 16'(n_exp)) begin errors++; $display("FAIL bp_sent_final: got %0d expected %0d", o_sent_count, n_exp); end
    checks++; if (o_gen_count !== 16'(gen30 + int'(g31))) begin errors++; $display("FAIL bp_gen_final: got %0d expected %0d", o_gen_count, gen30 + int'(g31)); end
    checks++; if (o_drop_count !== 16'(gen30 - 4)) begin errors++; $display("FAIL bp_drop_final: got %0d expected %0d", o_drop_count, gen30 - 4); end
  endtask

  task automatic test_zero_rate();
    int val_seen;
    i_enable = 1'b0;
    @(negedge clk);
    i_rate = 8'd0; i_en = 1'b1; i_pkt_limit = 16'd0; i_enable = 1'b1;
    val_seen = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (o_data_val) val_seen++;
      if (c == 1) begin
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL zero_done_cleared: got %0b expected 0", o_done); end
      end
    end
    checks++; if (val_seen != 0) begin errors++; $display("FAIL zero_data_val: got %0d valid cycles expected 0", val_seen); end
    checks++; if (o_gen_count !== 16'd0) begin errors++; $display("FAIL zero_gen_count: got %0d expected 0", o_gen_count); end
    i_enable = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL zero_done_2cyc: got %0b expected 1", o_done); end
  endtask

  task automatic test_mid_reset();
    bit reached, seen;
    logic [15:0] m;
    logic [3:0] exp_d;
    i_enable = 1'b0;
    @(negedge clk);
    i_en = 1'b0; i_rate = 8'd255; i_pkt_limit = 16'd0; i_enable = 1'b1;
    reached = 1'b0;
    for (int c = 0; c < 50 && !reached; c++) begin
      @(negedge clk);
      if (o_gen_count == 16'd3) reached = 1'b1;
    end
    checks++; if (!reached) begin errors++; $display("FAIL mr_queue3: got gen_count %0d expected 3 within 50 cycles", o_gen_count); end
    checks++; if (o_data_val !== 1'b1) begin errors++; $display("FAIL mr_queued_val: got %0b expected 1", o_data_val); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (o_data_val !== 1'b0) begin errors++; $display("FAIL mr_data_val: got %0b expected 0", o_data_val); end
    checks++; if (o_gen_count !== 16'd0) begin errors++; $display("FAIL mr_gen_count: got %0d expected 0", o_gen_count); end
    checks++; if (o_sent_count !== 16'd0) begin errors++; $display("FAIL mr_sent_count: got %0d expected 0", o_sent_count); end
    checks++; if (o_drop_count !== 16'd0) begin errors++; $display("FAIL mr_drop_count: got %0d expected 0", o_drop_count); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL mr_done: got %0b expected 0", o_done); end
    reset = 1'b0; i_en = 1'b1;
    m = 16'hACE1;
    while (m[7:0] == 8'hFF) m = lfsr_step(m);
    exp_d = model_dest(m, 0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (o_data_val) begin
        seen = 1'b1;
        checks++; if (o_seq !== 8'd0) begin errors++; $display("FAIL mr_restart_seq: got %0d expected 0", o_seq); end
        checks++; if (o_dest !== exp_d) begin errors++; $display("FAIL mr_restart_dest: got %0d expected %0d", o_dest, exp_d); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL mr_restart_val: got no packet expected one within 20 cycles"); end
    i_enable = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_remap();
    bit seen, done_seen;
    r_rate = 8'd1; r_limit = 16'd1; r_en = 1'b1; r_enable = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (r_data_val) begin
        seen = 1'b1;
        checks++; if (r_dest !== 4'd4) begin errors++; $display("FAIL remap_dest: got %0d expected 4", r_dest); end
        checks++; if (r_source !== 4'd3) begin errors++; $display("FAIL remap_source: got %0d expected 3", r_source); end
        checks++; if (r_seq !== 8'd0) begin errors++; $display("FAIL remap_seq: got %0d expected 0", r_seq); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL remap_val: got no packet expected one within 20 cycles"); end
    done_seen = 1'b0;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      @(negedge clk);
      if (r_done) done_seen = 1'b1;
    end
    checks++; if (!done_seen) begin errors++; $display("FAIL remap_done: got 0 expected 1 within 20 cycles"); end
    checks++; if (r_gen_count !== 16'd1 || r_sent_count !== 16'd1 || r_drop_count !== 16'd0) begin
      errors++; $display("FAIL remap_counts: got gen %0d sent %0d drop %0d expected 1 1 0", r_gen_count, r_sent_count, r_drop_count);
    end
  endtask

  initial begin
    reset = 1'b1; i_enable = 1'b0; i_rate = 8'd0; i_pkt_limit = 16'd0; i_en = 1'b0;
    r_enable = 1'b0; r_rate = 8'd0; r_limit = 16'd0; r_en = 1'b0;
    m_lfsr = 16'hACE1;
    test_reset();
    test_full_rate();
    test_backpressure();
    test_zero_rate();
    test_mid_reset();
    test_remap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
